// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter.
// FSM state encoding and requester identifiers, used by RTL and bench.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_e;

    localparam logic REQ_MON = 1'b0;
    localparam logic REQ_CPU = 1'b1;

    // Single full buffer wins outright; a tie goes to fixed or alternating priority.
    function automatic logic pick_winner(
        input logic m_full,
        input logic c_full,
        input logic fixed_prio,
        input logic last_grant
    );
        logic win;
        win = REQ_MON;
        if (m_full && !c_full) begin
            win = REQ_MON;
        end else if (c_full && !m_full) begin
            win = REQ_CPU;
        end else if (fixed_prio) begin
            win = REQ_MON;
        end else begin
            win = ~last_grant;
        end
        return win;
    endfunction

endpackage

// File: rtl/tx_hold_reg.sv
// One-entry valid/ready holding buffer for a single UART requester.
// Captures on valid && ready; emptied by clr when its byte is granted.
module tx_hold_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_valid && !full_q) begin
            full_d = 1'b1;
            data_d = in_data;
        end else if (clr) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready = !full_q;
    assign full     = full_q;
    assign out_data = data_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the monitor and the CPU.
// Optional per-requester byte counters when UART_ARB_COUNT_EN is defined.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIXED_PRIO    = 0,
    parameter int START_TIMEOUT = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_valid,
    input  logic [DATA_WIDTH-1:0] m_byte,
    output logic                  m_ready,
    input  logic                  c_valid,
    input  logic [DATA_WIDTH-1:0] c_byte,
    output logic                  c_ready,
    output logic [DATA_WIDTH-1:0] u_tx_byte,
    output logic                  u_transmit,
    input  logic                  u_is_transmitting,
    output logic                  owner_cpu,
    output logic                  busy
`ifdef UART_ARB_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  m_count,
    output logic [CNT_WIDTH-1:0]  c_count
`endif
);

    if (START_TIMEOUT < 1 || START_TIMEOUT > 15 || CNT_WIDTH < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: parameter out of range");
    end

    localparam logic [3:0] TimerLast = 4'(START_TIMEOUT - 1);

    logic                  m_full, c_full;
    logic [DATA_WIDTH-1:0] m_data, c_data;
    logic                  grant_m, grant_c;
    logic                  win;

    arb_state_e            state_q, state_d;
    logic [3:0]            timer_q, timer_d;
    logic                  transmit_q, transmit_d;
    logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;

    tx_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold_m (
        .clk      (clk),
        .rst      (rst),
        .clr      (grant_m),
        .in_valid (m_valid),
        .in_data  (m_byte),
        .in_ready (m_ready),
        .full     (m_full),
        .out_data (m_data)
    );

    tx_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold_c (
        .clk      (clk),
        .rst      (rst),
        .clr      (grant_c),
        .in_valid (c_valid),
        .in_data  (c_byte),
        .in_ready (c_ready),
        .full     (c_full),
        .out_data (c_data)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        last_d     = last_q;
        owner_d    = owner_q;
        grant_m    = 1'b0;
        grant_c    = 1'b0;
        win        = pick_winner(m_full, c_full, FIXED_PRIO != 0, last_q);
        unique case (state_q)
            ARB_IDLE: begin
                if ((m_full || c_full) && !u_is_transmitting) begin
                    grant_m    = (win == REQ_MON);
                    grant_c    = (win == REQ_CPU);
                    tx_byte_d  = (win == REQ_CPU) ? c_data : m_data;
                    transmit_d = 1'b1;
                    last_d     = win;
                    owner_d    = win;
                    timer_d    = '0;
                    state_d    = ARB_START;
                end
            end
            ARB_START: begin
                // A UART that never starts is given up on; the byte is dropped.
                if (u_is_transmitting) begin
                    state_d = ARB_BUSY;
                end else if (timer_q == TimerLast) begin
                    state_d = ARB_IDLE;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            ARB_BUSY: begin
                if (!u_is_transmitting) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            timer_q    <= '0;
            transmit_q <= 1'b0;
            tx_byte_q  <= '0;
            last_q     <= REQ_CPU;
            owner_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
        end
    end

`ifdef UART_ARB_COUNT_EN
    logic [CNT_WIDTH-1:0] m_cnt_q, m_cnt_d;
    logic [CNT_WIDTH-1:0] c_cnt_q, c_cnt_d;

    always_comb begin
        m_cnt_d = m_cnt_q;
        c_cnt_d = c_cnt_q;
        if (grant_m) begin
            m_cnt_d = m_cnt_q + 1'b1;
        end
        if (grant_c) begin
            c_cnt_d = c_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            m_cnt_q <= m_cnt_d;
            c_cnt_q <= c_cnt_d;
        end
    end

    assign m_count = m_cnt_q;
    assign c_count = c_cnt_q;
`endif

    // Reset kills a pending pulse immediately rather than at the next edge.
    assign u_transmit = transmit_q && !rst;
    assign u_tx_byte  = tx_byte_q;
    assign owner_cpu  = owner_q;
    assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin and fixed-priority instances.
// Counter checks run only when UART_ARB_COUNT_EN is defined.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       m_valid0, c_valid0, m_ready0, c_ready0;
    logic [7:0] m_byte0, c_byte0, tx0;
    logic       tr0, ist0, own0, busy0;
    logic       m_valid1, c_valid1, m_ready1, c_ready1;
    logic [7:0] m_byte1, c_byte1, tx1;
    logic       tr1, ist1, own1, busy1;
`ifdef UART_ARB_COUNT_EN
    logic [3:0] m_cnt0, c_cnt0;
    logic [3:0] m_cnt1, c_cnt1;
`endif

    uart_tx_arbiter #(
        .DATA_WIDTH(8), .FIXED_PRIO(0), .START_TIMEOUT(4), .CNT_WIDTH(4)
    ) dut0 (
        .clk(clk), .rst(rst),
        .m_valid(m_valid0), .m_byte(m_byte0), .m_ready(m_ready0),
        .c_valid(c_valid0), .c_byte(c_byte0), .c_ready(c_ready0),
        .u_tx_byte(tx0), .u_transmit(tr0), .u_is_transmitting(ist0),
        .owner_cpu(own0), .busy(busy0)
`ifdef UART_ARB_COUNT_EN
        , .m_count(m_cnt0), .c_count(c_cnt0)
`endif
    );

    uart_tx_arbiter #(
        .DATA_WIDTH(8), .FIXED_PRIO(1), .START_TIMEOUT(4), .CNT_WIDTH(4)
    ) dut1 (
        .clk(clk), .rst(rst),
        .m_valid(m_valid1), .m_byte(m_byte1), .m_ready(m_ready1),
        .c_valid(c_valid1), .c_byte(c_byte1), .c_ready(c_ready1),
        .u_tx_byte(tx1), .u_transmit(tr1), .u_is_transmitting(ist1),
        .owner_cpu(own1), .busy(busy1)
`ifdef UART_ARB_COUNT_EN
        , .m_count(m_cnt1), .c_count(c_cnt1)
`endif
    );

    // UART models: is_transmitting rises the cycle after a pulse for blen cycles.
    logic resp0, resp1;
    int   blen0, blen1;
    int   cnt0 = 0;
    int   cnt1 = 0;
    int   cyc  = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         t0[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tr0 && resp0) cnt0 <= blen0;
        else if (cnt0 > 0) cnt0 <= cnt0 - 1;
        if (tr1 && resp1) cnt1 <= blen1;
        else if (cnt1 > 0) cnt1 <= cnt1 - 1;
        if (tr0) begin
            q0.push_back(tx0);
            t0.push_back(cyc);
        end
        if (tr1) q1.push_back(tx1);
    end

    assign ist0 = (cnt0 > 0);
    assign ist1 = (cnt1 > 0);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_quiet0(input string tag, input int budget);
        int n;
        n = 0;
        while (!(!busy0 && m_ready0 && c_ready0 && !ist0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_both0(input string tag, input int budget);
        int n;
        n = 0;
        while (!(m_ready0 && c_ready0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int  n;
        logic all_mon;
        rst = 1'b1;
        m_valid0 = 0; c_valid0 = 0; m_byte0 = 0; c_byte0 = 0;
        m_valid1 = 0; c_valid1 = 0; m_byte1 = 0; c_byte1 = 0;
        resp0 = 1; blen0 = 20; resp1 = 1; blen1 = 3;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst m_ready", 32'(m_ready0), 32'd1);
        chk("rst c_ready", 32'(c_ready0), 32'd1);
        chk("rst u_transmit", 32'(tr0), 32'd0);
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst owner_cpu", 32'(own0), 32'd0);
        chk("rst u_tx_byte", 32'(tx0), 32'd0);
`ifdef UART_ARB_COUNT_EN
        chk("rst c_count", 32'(c_cnt0), 32'd0);
`endif

        // single monitor byte
        q0.delete();
        m_valid0 = 1; m_byte0 = 8'h41;
        @(negedge clk);
        chk("t1 m_ready low", 32'(m_ready0), 32'd0);
        chk("t1 no early pulse", 32'(tr0), 32'd0);
        m_valid0 = 0;
        @(negedge clk);
        chk("t1 pulse", 32'(tr0), 32'd1);
        chk("t1 byte", 32'(tx0), 32'h41);
        chk("t1 owner", 32'(own0), 32'(REQ_MON));
        chk("t1 m_ready back", 32'(m_ready0), 32'd1);
        chk("t1 busy", 32'(busy0), 32'd1);
        @(negedge clk);
        chk("t1 pulse width", 32'(tr0), 32'd0);
        chk("t1 byte hold", 32'(tx0), 32'h41);
        wait_quiet0("t1 quiet timeout", 80);
        chk("t1 pulse count", 32'(q0.size()), 32'd1);

        // round-robin tie, three rounds
        do_reset();
        q0.delete(); t0.delete();
        for (int r = 0; r < 3; r++) begin
            wait_both0("t2 ready timeout", 100);
            m_valid0 = 1; c_valid0 = 1; m_byte0 = 8'h10; c_byte0 = 8'h20;
            @(negedge clk);
            m_valid0 = 0; c_valid0 = 0;
        end
        wait_quiet0("t2 quiet timeout", 200);
        chk("t2 pulse count", 32'(q0.size()), 32'd6);
        for (int i = 0; i < 6 && i < q0.size(); i++) begin
            chk($sformatf("t2 order %0d", i), 32'(q0[i]), (i % 2 == 1) ? 32'h20 : 32'h10);
            if (i > 0) chk($sformatf("t2 gap %0d", i), 32'(t0[i] - t0[i-1] > 20), 32'd1);
        end

        // UART never starts: timeout recovery
        do_reset();
        resp0 = 0;
        q0.delete();
        m_valid0 = 1; c_valid0 = 1; m_byte0 = 8'h55; c_byte0 = 8'h66;
        @(negedge clk);
        m_valid0 = 0; c_valid0 = 0;
        @(negedge clk);
        chk("t4 pulse 1", 32'(tr0), 32'd1);
        chk("t4 byte 1", 32'(tx0), 32'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t4 start %0d", i), 32'(busy0), 32'd1);
        end
        @(negedge clk);
        chk("t4 timeout idle", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("t4 pulse 2", 32'(tr0), 32'd1);
        chk("t4 byte 2", 32'(tx0), 32'h66);
        chk("t4 owner", 32'(own0), 32'(REQ_CPU));
        repeat (6) @(negedge clk);
        chk("t4 idle again", 32'(busy0), 32'd0);
        chk("t4 pulse count", 32'(q0.size()), 32'd2);
        resp0 = 1;

        // reset the cycle after a pulse with both buffers full
        do_reset();
        q0.delete();
        m_valid0 = 1; c_valid0 = 1; m_byte0 = 8'h31; c_byte0 = 8'h32;
        @(negedge clk);
        m_valid0 = 0; c_valid0 = 0;
        @(negedge clk);
        chk("t5 pulse", 32'(tr0), 32'd1);
        m_valid0 = 1; m_byte0 = 8'h77;
        @(negedge clk);
        m_valid0 = 0;
        chk("t5 m full", 32'(m_ready0), 32'd0);
        chk("t5 c full", 32'(c_ready0), 32'd0);
        rst = 1'b1;
        chk("t5 no pulse in rst", 32'(tr0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("t5 u_transmit", 32'(tr0), 32'd0);
        chk("t5 m_ready", 32'(m_ready0), 32'd1);
        chk("t5 c_ready", 32'(c_ready0), 32'd1);
        chk("t5 busy", 32'(busy0), 32'd0);
        repeat (40) @(negedge clk);
        chk("t5 pulse count", 32'(q0.size()), 32'd1);
        if (q0.size() > 0) chk("t5 only first", 32'(q0[0]), 32'h31);

        // fixed priority instance
        q1.delete();
        m_valid1 = 1; c_valid1 = 1; m_byte1 = 8'hA1; c_byte1 = 8'hC1;
        n = 0;
        while (q1.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t3 mon timeout", 32'(n < 200), 32'd1);
        m_valid1 = 0;
        n = 0;
        while ((q1.size() == 0 || q1[$] == 8'hA1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        c_valid1 = 0;
        chk("t3 cpu timeout", 32'(n < 200), 32'd1);
        if (q1.size() > 0) chk("t3 cpu byte", 32'(q1[$]), 32'hC1);
        all_mon = 1'b1;
        for (int i = 0; i + 1 < q1.size(); i++) if (q1[i] != 8'hA1) all_mon = 1'b0;
        chk("t3 mon only before", 32'(all_mon), 32'd1);
        chk("t3 mon count", 32'(q1.size() >= 5), 32'd1);

`ifdef UART_ARB_COUNT_EN
        do_reset();
        blen0 = 2;
        q0.delete();
        for (int i = 0; i < 17; i++) begin
            n = 0;
            while (!c_ready0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("t6 ready timeout", 32'(n < 50), 32'd1);
            c_valid0 = 1; c_byte0 = 8'(i);
            @(negedge clk);
            c_valid0 = 0;
        end
        wait_quiet0("t6 quiet timeout", 100);
        chk("t6 pulses", 32'(q0.size()), 32'd17);
        chk("t6 c_count wrap", 32'(c_cnt0), 32'd1);
        chk("t6 m_count", 32'(m_cnt0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
